// File: rtl/tpx3_shutter_pkg.sv
// Shared definitions for the Timepix3 shutter sequencer: state encoding and default widths.
package tpx3_shutter_pkg;

    localparam int CNT_WIDTH_DEF = 32;
    localparam int REP_WIDTH_DEF = 16;
    localparam int T0_WIDTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_DLY  = 3'd2,
        ST_OPEN = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/tpx3_seq_counter.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module tpx3_seq_counter #(
    parameter int WIDTH = 32
) (
    input  logic             BUS_CLK,
    input  logic             BUS_RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic             ZERO
);

    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_r;

    // Count register: load on state entry, otherwise decrement and saturate at zero.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            cnt_r <= ZERO_C;
        end else if (LOAD) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != ZERO_C) begin
            cnt_r <= cnt_r - ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign ZERO = (cnt_r == ZERO_C);

endmodule

// File: rtl/tpx3_shutter_seq.sv
// Shutter sequencer: T0 pulse, optional delay, then a train of open/closed shutter windows.
module tpx3_shutter_seq
    import tpx3_shutter_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int REP_WIDTH = REP_WIDTH_DEF
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [T0_WIDTH-1:0]  T0_LEN,
    input  logic [CNT_WIDTH-1:0] DELAY,
    input  logic [CNT_WIDTH-1:0] OPEN_LEN,
    input  logic [CNT_WIDTH-1:0] CLOSED_LEN,
    input  logic [REP_WIDTH-1:0] REPEAT,
    output logic                 T0_SYNC,
    output logic                 SHUTTER,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [REP_WIDTH-1:0] FRAME_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REP_WIDTH-1:0] REP_ZERO = {REP_WIDTH{1'b0}};
    localparam logic [REP_WIDTH-1:0] REP_ONE  = {{(REP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [T0_WIDTH-1:0]  T0_ZERO  = {T0_WIDTH{1'b0}};

    // Counter preload for a phase of 'len' cycles; a zero length behaves as one cycle.
    function automatic logic [CNT_WIDTH-1:0] len_to_load(input logic [CNT_WIDTH-1:0] len);
        return (len == CNT_ZERO) ? CNT_ZERO : (len - CNT_ONE);
    endfunction

    state_t                state_r, state_s;
    logic [T0_WIDTH-1:0]   t0_len_r;
    logic [CNT_WIDTH-1:0]  delay_r, open_len_r, closed_len_r;
    logic [REP_WIDTH-1:0]  repeat_r, frame_r, frame_s, frame_inc_s;
    logic [T0_WIDTH-1:0]   cfg_t0_s;
    logic [CNT_WIDTH-1:0]  cfg_delay_s, cfg_open_s, cfg_closed_s;
    logic [CNT_WIDTH-1:0]  load_val_s;
    logic                  load_s, latch_s, done_s, cnt_zero_s;
    logic                  t0_sync_r, shutter_r, busy_r, done_r;

    tpx3_seq_counter #(.WIDTH(CNT_WIDTH)) u_counter (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .LOAD     (load_s),
        .LOAD_VAL (load_val_s),
        .ZERO     (cnt_zero_s)
    );

    // Configuration source: live inputs on the accepting cycle, shadow copies afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cfg_t0_s     = T0_LEN;
            cfg_delay_s  = DELAY;
            cfg_open_s   = OPEN_LEN;
            cfg_closed_s = CLOSED_LEN;
        end else begin
            cfg_t0_s     = t0_len_r;
            cfg_delay_s  = delay_r;
            cfg_open_s   = open_len_r;
            cfg_closed_s = closed_len_r;
        end
    end

    // Next-state, frame counting and sequence-end detection.
    always_comb begin
        state_s     = state_r;
        frame_s     = frame_r;
        frame_inc_s = frame_r + REP_ONE;
        done_s      = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START && !STOP) begin
                    latch_s = 1'b1;
                    frame_s = REP_ZERO;
                    if (T0_LEN != T0_ZERO) begin
                        state_s = ST_T0;
                    end else if (DELAY != CNT_ZERO) begin
                        state_s = ST_DLY;
                    end else begin
                        state_s = ST_OPEN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_T0: begin
                if (STOP) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (cnt_zero_s) begin
                    state_s = (delay_r != CNT_ZERO) ? ST_DLY : ST_OPEN;
                end else begin
                    state_s = ST_T0;
                end
            end
            ST_DLY: begin
                if (STOP) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (cnt_zero_s) begin
                    state_s = ST_OPEN;
                end else begin
                    state_s = ST_DLY;
                end
            end
            ST_OPEN: begin
                if (STOP) begin
                    // An aborted window is a partial frame and is not counted.
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (cnt_zero_s) begin
                    frame_s = frame_inc_s;
                    if ((repeat_r != REP_ZERO) && (frame_inc_s == repeat_r)) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else begin
                    state_s = ST_OPEN;
                end
            end
            ST_GAP: begin
                if (STOP) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (cnt_zero_s) begin
                    state_s = ST_OPEN;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Counter preload selected by the phase being entered.
    always_comb begin
        load_s = (state_s != state_r);
        case (state_s)
            ST_T0:   load_val_s = len_to_load(CNT_WIDTH'(cfg_t0_s));
            ST_DLY:  load_val_s = len_to_load(cfg_delay_s);
            ST_OPEN: load_val_s = len_to_load(cfg_open_s);
            ST_GAP:  load_val_s = len_to_load(cfg_closed_s);
            default: load_val_s = CNT_ZERO;
        endcase
    end

    // State, shadow configuration, frame count and registered outputs.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_r      <= ST_IDLE;
            t0_len_r     <= T0_ZERO;
            delay_r      <= CNT_ZERO;
            open_len_r   <= CNT_ZERO;
            closed_len_r <= CNT_ZERO;
            repeat_r     <= REP_ZERO;
            frame_r      <= REP_ZERO;
            t0_sync_r    <= 1'b0;
            shutter_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            frame_r <= frame_s;
            if (latch_s) begin
                t0_len_r     <= T0_LEN;
                delay_r      <= DELAY;
                open_len_r   <= OPEN_LEN;
                closed_len_r <= CLOSED_LEN;
                repeat_r     <= REPEAT;
            end
            t0_sync_r <= (state_s == ST_T0);
            shutter_r <= (state_s == ST_OPEN);
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= done_s;
        end
    end

    assign T0_SYNC   = t0_sync_r;
    assign SHUTTER   = shutter_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign FRAME_CNT = frame_r;

endmodule

// File: tb/tb_tpx3_shutter_seq.sv
// Directed self-checking bench for tpx3_shutter_seq; a second 4-bit-repeat instance covers counter wrap.
module tb_tpx3_shutter_seq;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST, START, STOP, START4, STOP4;
    logic [15:0] T0_LEN;
    logic [31:0] DELAY, OPEN_LEN, CLOSED_LEN;
    logic [15:0] REPEAT;
    logic [3:0]  REPEAT4;
    logic        T0_SYNC, SHUTTER, BUSY, DONE;
    logic [15:0] FRAME_CNT;
    logic        T0_SYNC4, SHUTTER4, BUSY4, DONE4;
    logic [3:0]  FRAME_CNT4;

    int checks = 0;
    int errors = 0;

    tpx3_shutter_seq dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .START(START), .STOP(STOP),
        .T0_LEN(T0_LEN), .DELAY(DELAY), .OPEN_LEN(OPEN_LEN), .CLOSED_LEN(CLOSED_LEN),
        .REPEAT(REPEAT), .T0_SYNC(T0_SYNC), .SHUTTER(SHUTTER), .BUSY(BUSY),
        .DONE(DONE), .FRAME_CNT(FRAME_CNT)
    );

    tpx3_shutter_seq #(.CNT_WIDTH(32), .REP_WIDTH(4)) dut4 (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .START(START4), .STOP(STOP4),
        .T0_LEN(T0_LEN), .DELAY(DELAY), .OPEN_LEN(OPEN_LEN), .CLOSED_LEN(CLOSED_LEN),
        .REPEAT(REPEAT4), .T0_SYNC(T0_SYNC4), .SHUTTER(SHUTTER4), .BUSY(BUSY4),
        .DONE(DONE4), .FRAME_CNT(FRAME_CNT4)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] t0, input logic [31:0] dl, input logic [31:0] op,
                           input logic [31:0] cl, input logic [15:0] rp);
        T0_LEN = t0; DELAY = dl; OPEN_LEN = op; CLOSED_LEN = cl; REPEAT = rp;
    endtask

    task automatic test_reset();
        BUS_RST = 1'b1; START = 1'b0; STOP = 1'b0; START4 = 1'b0; STOP4 = 1'b0;
        set_cfg(16'd0, 32'd0, 32'd0, 32'd0, 16'd0);
        REPEAT4 = 4'd0;
        tick(); tick(); tick();
        checks++;
        if ({T0_SYNC, SHUTTER, BUSY, DONE, FRAME_CNT} !== 20'd0) begin
            errors++;
            $display("FAIL reset: got %h required 00000", {T0_SYNC, SHUTTER, BUSY, DONE, FRAME_CNT});
        end
        checks++;
        if ({T0_SYNC4, SHUTTER4, BUSY4, DONE4, FRAME_CNT4} !== 8'd0) begin
            errors++;
            $display("FAIL reset4: got %h required 00", {T0_SYNC4, SHUTTER4, BUSY4, DONE4, FRAME_CNT4});
        end
        BUS_RST = 1'b0;
        tick();
    endtask

    task automatic test_full_sequence();
        logic [3:0]  exp_o;
        logic [15:0] exp_f;
        set_cfg(16'd4, 32'd10, 32'd20, 32'd5, 16'd3);
        tick(); START = 1'b1;
        tick(); START = 1'b0;
        for (int e = 1; e <= 90; e++) begin
            if (e > 1) tick();
            exp_o[3] = (e >= 1 && e <= 4);
            exp_o[2] = (e >= 15 && e <= 34) || (e >= 40 && e <= 59) || (e >= 65 && e <= 84);
            exp_o[1] = (e >= 1 && e <= 84);
            exp_o[0] = (e == 85);
            exp_f = (e >= 85) ? 16'd3 : (e >= 60) ? 16'd2 : (e >= 35) ? 16'd1 : 16'd0;
            checks++;
            if ({T0_SYNC, SHUTTER, BUSY, DONE} !== exp_o || FRAME_CNT !== exp_f) begin
                errors++;
                $display("FAIL full_seq edge %0d: got t0/sh/busy/done=%b frame=%0d required %b frame=%0d",
                         e, {T0_SYNC, SHUTTER, BUSY, DONE}, FRAME_CNT, exp_o, exp_f);
            end
        end
    endtask

    task automatic test_zero_lengths();
        logic [3:0]  exp_o;
        logic [15:0] exp_f;
        set_cfg(16'd0, 32'd0, 32'd0, 32'd0, 16'd2);
        tick(); START = 1'b1;
        tick(); START = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            if (e > 1) tick();
            exp_o = {1'b0, (e == 1 || e == 3), (e <= 3), (e == 4)};
            exp_f = (e >= 4) ? 16'd2 : (e >= 2) ? 16'd1 : 16'd0;
            checks++;
            if ({T0_SYNC, SHUTTER, BUSY, DONE} !== exp_o || FRAME_CNT !== exp_f) begin
                errors++;
                $display("FAIL zero_len edge %0d: got %b frame=%0d required %b frame=%0d",
                         e, {T0_SYNC, SHUTTER, BUSY, DONE}, FRAME_CNT, exp_o, exp_f);
            end
        end
    endtask

    task automatic test_stop_abort();
        logic [15:0] exp_f;
        set_cfg(16'd0, 32'd0, 32'd8, 32'd2, 16'd0);
        tick(); START = 1'b1;
        tick(); START = 1'b0;
        for (int e = 1; e <= 43; e++) begin
            if (e > 1) tick();
            exp_f = 16'((e + 1) / 10);
            checks++;
            if (SHUTTER !== (((e - 1) % 10) < 8) || BUSY !== 1'b1 || FRAME_CNT !== exp_f) begin
                errors++;
                $display("FAIL stop_run edge %0d: got sh=%b busy=%b frame=%0d required sh=%b busy=1 frame=%0d",
                         e, SHUTTER, BUSY, FRAME_CNT, (((e - 1) % 10) < 8), exp_f);
            end
        end
        STOP = 1'b1;
        tick(); STOP = 1'b0;
        checks++;
        if ({T0_SYNC, SHUTTER, BUSY, DONE} !== 4'b0001 || FRAME_CNT !== 16'd4) begin
            errors++;
            $display("FAIL stop_abort: got %b frame=%0d required 0001 frame=4", {T0_SYNC, SHUTTER, BUSY, DONE}, FRAME_CNT);
        end
        tick();
        checks++;
        if ({T0_SYNC, SHUTTER, BUSY, DONE} !== 4'b0000 || FRAME_CNT !== 16'd4) begin
            errors++;
            $display("FAIL stop_after: got %b frame=%0d required 0000 frame=4", {T0_SYNC, SHUTTER, BUSY, DONE}, FRAME_CNT);
        end
    endtask

    task automatic test_busy_collision();
        logic [3:0]  exp_o;
        logic [15:0] exp_f;
        set_cfg(16'd0, 32'd0, 32'd3, 32'd2, 16'd2);
        tick(); START = 1'b1;
        tick(); START = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            if (e > 1) tick();
            exp_o = {1'b0, (e <= 3) || (e >= 6 && e <= 8), (e <= 8), (e == 9)};
            exp_f = (e >= 9) ? 16'd2 : (e >= 4) ? 16'd1 : 16'd0;
            checks++;
            if ({T0_SYNC, SHUTTER, BUSY, DONE} !== exp_o || FRAME_CNT !== exp_f) begin
                errors++;
                $display("FAIL busy_ignore edge %0d: got %b frame=%0d required %b frame=%0d",
                         e, {T0_SYNC, SHUTTER, BUSY, DONE}, FRAME_CNT, exp_o, exp_f);
            end
            if (e == 1) begin
                START = 1'b1; OPEN_LEN = 32'd10;
            end else if (e == 2) begin
                START = 1'b0; OPEN_LEN = 32'd3;
            end
        end
        START = 1'b1;
        tick(); START = 1'b0;
        checks++;
        if ({SHUTTER, BUSY, DONE} !== 3'b110 || FRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL restart_after_done: got sh/busy/done=%b frame=%0d required 110 frame=0", {SHUTTER, BUSY, DONE}, FRAME_CNT);
        end
        STOP = 1'b1;
        tick(); STOP = 1'b0;
        checks++;
        if ({SHUTTER, BUSY, DONE} !== 3'b001) begin
            errors++;
            $display("FAIL restart_stop: got %b required 001", {SHUTTER, BUSY, DONE});
        end
        tick();
        START = 1'b1; STOP = 1'b1;
        tick(); START = 1'b0; STOP = 1'b0;
        checks++;
        if ({T0_SYNC, SHUTTER, BUSY, DONE} !== 4'b0000) begin
            errors++;
            $display("FAIL start_stop_idle: got %b required 0000", {T0_SYNC, SHUTTER, BUSY, DONE});
        end
        tick();
        checks++;
        if ({T0_SYNC, SHUTTER, BUSY, DONE} !== 4'b0000) begin
            errors++;
            $display("FAIL start_stop_idle2: got %b required 0000", {T0_SYNC, SHUTTER, BUSY, DONE});
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  exp_o;
        logic [15:0] exp_f;
        set_cfg(16'd0, 32'd0, 32'd5, 32'd1, 16'd0);
        tick(); START = 1'b1;
        tick(); START = 1'b0;
        tick(); tick();
        checks++;
        if (SHUTTER !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_open: got sh=%b busy=%b required 1 1", SHUTTER, BUSY);
        end
        BUS_RST = 1'b1;
        tick();
        checks++;
        if ({T0_SYNC, SHUTTER, BUSY, DONE, FRAME_CNT} !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h required 00000", {T0_SYNC, SHUTTER, BUSY, DONE, FRAME_CNT});
        end
        BUS_RST = 1'b0;
        tick();
        checks++;
        if ({T0_SYNC, SHUTTER, BUSY, DONE} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_nodone: got %b required 0000", {T0_SYNC, SHUTTER, BUSY, DONE});
        end
        set_cfg(16'd2, 32'd1, 32'd2, 32'd1, 16'd1);
        START = 1'b1;
        tick(); START = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            if (e > 1) tick();
            exp_o = {(e <= 2), (e == 4 || e == 5), (e <= 5), (e == 6)};
            exp_f = (e >= 6) ? 16'd1 : 16'd0;
            checks++;
            if ({T0_SYNC, SHUTTER, BUSY, DONE} !== exp_o || FRAME_CNT !== exp_f) begin
                errors++;
                $display("FAIL post_reset_seq edge %0d: got %b frame=%0d required %b frame=%0d",
                         e, {T0_SYNC, SHUTTER, BUSY, DONE}, FRAME_CNT, exp_o, exp_f);
            end
        end
    endtask

    task automatic test_wrap();
        set_cfg(16'd0, 32'd0, 32'd1, 32'd1, 16'd0);
        REPEAT4 = 4'd0;
        tick(); START4 = 1'b1;
        tick(); START4 = 1'b0;
        for (int e = 1; e <= 35; e++) begin
            if (e > 1) tick();
            if (e == 30 || e == 32 || e == 34) begin
                checks++;
                if (FRAME_CNT4 !== 4'((e / 2) % 16)) begin
                    errors++;
                    $display("FAIL wrap_count edge %0d: got %0d required %0d", e, FRAME_CNT4, (e / 2) % 16);
                end
            end
        end
        checks++;
        if (SHUTTER4 !== 1'b1 || BUSY4 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_running: got sh=%b busy=%b required 1 1", SHUTTER4, BUSY4);
        end
        STOP4 = 1'b1;
        tick(); STOP4 = 1'b0;
        checks++;
        if ({SHUTTER4, BUSY4, DONE4} !== 3'b001 || FRAME_CNT4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_stop: got sh/busy/done=%b frame=%0d required 001 frame=1", {SHUTTER4, BUSY4, DONE4}, FRAME_CNT4);
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_zero_lengths();
        test_stop_abort();
        test_busy_collision();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
